// File: rtl/fetch_queue_pkg.sv
//------------------------------------------------------------------------------
// Module  : fetch_queue_pkg
// Brief   : Shared constants and types for the fetch queue.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_queue_pkg;

   localparam logic [31:0] c_NOP_INSTR     = 32'h0000_0013;
   localparam int          c_DEFAULT_DEPTH = 4;

   typedef struct packed {
      logic [31:0] instruction;
      logic [63:0] pc;
   } fetchEntry_t;

endpackage : fetch_queue_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module  : fetch_queue
// Brief   : Instruction queue between fetch and the FD pipeline register.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = c_DEFAULT_DEPTH
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   input  logic [31:0]              instruction_i,
   input  logic [63:0]              PC_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [31:0]              instruction_o,
   output logic [63:0]              PC_o,
   input  logic                     ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_PTR_W = c_IDX_W + 1;

   logic [c_PTR_W-1:0] r_wrPtr;
   logic [c_PTR_W-1:0] r_rdPtr;
   fetchEntry_t        r_mem [DEPTH];

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   fetchEntry_t        w_head;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign w_full  = (r_wrPtr[c_PTR_W-1] != r_rdPtr[c_PTR_W-1]) &&
                    (r_wrPtr[c_IDX_W-1:0] == r_rdPtr[c_IDX_W-1:0]);
   assign w_empty = (r_wrPtr == r_rdPtr);

   assign ready_o = !w_full;
   assign valid_o = !w_empty;
   assign count_o = r_wrPtr - r_rdPtr;

   assign w_push  = valid_i && ready_o && !flush_i;
   assign w_pop   = valid_o && ready_i && !flush_i;
   assign w_head  = r_mem[r_rdPtr[c_IDX_W-1:0]];

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      end
   end

   // Storage is deliberately left out of reset; only the pointers matter.
   always_ff @(posedge clk_i) begin
      if (w_push && !reset_i) begin
         r_mem[r_wrPtr[c_IDX_W-1:0]] <= '{instruction: instruction_i, pc: PC_i};
      end
   end

   always_comb begin
      instruction_o = c_NOP_INSTR;
      PC_o          = '0;
      if (valid_o) begin
         instruction_o = w_head.instruction;
         PC_o          = w_head.pc;
      end
   end

endmodule : fetch_queue

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_queue
// Brief   : Scoreboard bench for fetch_queue with directed stimulus.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [31:0] instruction_i = '0;
   logic [63:0] PC_i = '0;
   logic        ready_i = 1'b0;
   logic        ready_o;
   logic        valid_o;
   logic [31:0] instruction_o;
   logic [63:0] PC_o;
   logic [2:0]  count_o;

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .flush_i       (flush_i),
      .valid_i       (valid_i),
      .instruction_i (instruction_i),
      .PC_i          (PC_i),
      .ready_o       (ready_o),
      .valid_o       (valid_o),
      .instruction_o (instruction_o),
      .PC_o          (PC_o),
      .ready_i       (ready_i),
      .count_o       (count_o)
   );

   always #5 clk_i = ~clk_i;

   fetchEntry_t sbq[$];
   int          mCount   = 0;
   int          checks   = 0;
   int          errors   = 0;
   bit          checkEn  = 1'b0;
   bit          holdPrev = 1'b0;
   logic [31:0] holdInstr;
   logic [63:0] holdPc;

   // Drive one cycle of inputs, predict the queue's response, advance one edge.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                        input logic rdy, input logic fl, input logic rst);
      bit doPush;
      bit doPop;
      doPush = v && (mCount != DEPTH) && !fl && !rst;
      doPop  = rdy && (mCount != 0) && !fl && !rst;
      if (rst || fl) sbq.delete();
      if (doPush) sbq.push_back('{instruction: ins, pc: pc});
      valid_i = v; instruction_i = ins; PC_i = pc;
      ready_i = rdy; flush_i = fl; reset_i = rst;
      @(posedge clk_i);
      if (rst || fl) mCount = 0;
      else mCount = mCount + int'(doPush) - int'(doPop);
      #1;
   endtask

   task automatic push(input logic [31:0] ins, input logic [63:0] pc, input logic rdy);
      cycle(1'b1, ins, pc, rdy, 1'b0, 1'b0);
   endtask

   task automatic idle(input logic rdy, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 64'h0, rdy, 1'b0, 1'b0);
   endtask

   // Monitor: state checks every cycle, head compared whenever a pop is due.
   always @(negedge clk_i) begin
      if (checkEn) begin
         checks++;
         if (int'(count_o) != mCount) begin
            errors++;
            $display("FAIL count: got %0d expected %0d at %0t", count_o, mCount, $time);
         end
         checks++;
         if (ready_o != (mCount != DEPTH)) begin
            errors++;
            $display("FAIL ready_o: got %0b expected %0b at %0t", ready_o, mCount != DEPTH, $time);
         end
         checks++;
         if (valid_o != (mCount != 0)) begin
            errors++;
            $display("FAIL valid_o: got %0b expected %0b at %0t", valid_o, mCount != 0, $time);
         end
         if (mCount == 0) begin
            checks++;
            if (instruction_o != c_NOP_INSTR || PC_o != 64'h0) begin
               errors++;
               $display("FAIL empty_outputs: got %h/%h expected %h/0 at %0t",
                        instruction_o, PC_o, c_NOP_INSTR, $time);
            end
         end
         if (holdPrev) begin
            checks++;
            if (instruction_o != holdInstr || PC_o != holdPc) begin
               errors++;
               $display("FAIL hold: got %h/%h expected %h/%h at %0t",
                        instruction_o, PC_o, holdInstr, holdPc, $time);
            end
         end
         if (mCount != 0 && ready_i && !flush_i && !reset_i) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL pop: got %h/%h expected no entry at %0t", instruction_o, PC_o, $time);
            end else begin
               if (instruction_o != sbq[0].instruction || PC_o != sbq[0].pc) begin
                  errors++;
                  $display("FAIL pop: got %h/%h expected %h/%h at %0t",
                           instruction_o, PC_o, sbq[0].instruction, sbq[0].pc, $time);
               end
               void'(sbq.pop_front());
            end
         end
         holdPrev  = (mCount != 0) && !ready_i && !flush_i && !reset_i;
         holdInstr = instruction_o;
         holdPc    = PC_o;
      end
   end

   initial begin
      cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      checkEn = 1'b1;
      cycle(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b1);
      idle(1'b0, 1);

      // Single push visible the next cycle, then consumed
      push(32'h0050_0093, 64'h0, 1'b0);
      idle(1'b1, 2);

      // Fill to DEPTH, reject extra pushes (also alongside a pop), drain in order
      push(32'h0010_0093, 64'h0, 1'b0);
      push(32'h0020_0093, 64'h4, 1'b0);
      push(32'h0030_0093, 64'h8, 1'b0);
      push(32'h0040_0093, 64'hC, 1'b0);
      push(32'hDEAD_BEEF, 64'h10, 1'b0);
      push(32'hBAD0_0001, 64'h14, 1'b1);
      idle(1'b1, 4);

      // Steady push+pop at occupancy 2 across pointer wrap
      push(32'h1000_0001, 64'h100, 1'b0);
      push(32'h1000_0002, 64'h104, 1'b0);
      for (int i = 0; i < 8; i++)
         push(32'h2000_0000 + 32'(i), 64'h200 + 64'(4 * i), 1'b1);
      idle(1'b1, 3);

      // Flush with a concurrent push: queue empties, pushed word dropped
      push(32'h3000_0001, 64'h300, 1'b0);
      push(32'h3000_0002, 64'h304, 1'b0);
      push(32'h3000_0003, 64'h308, 1'b0);
      cycle(1'b1, 32'h3BAD_0004, 64'h30C, 1'b0, 1'b1, 1'b0);
      idle(1'b0, 1);
      push(32'h3000_0005, 64'h310, 1'b0);
      idle(1'b1, 2);

      // Head held for 5 cycles while pushes arrive
      push(32'h4000_0000, 64'h400, 1'b0);
      for (int i = 1; i <= 5; i++)
         push(32'h4000_0000 + 32'(i), 64'h400 + 64'(4 * i), 1'b0);
      idle(1'b1, 5);

      // Reset and flush together on a full queue
      push(32'h5000_0001, 64'h500, 1'b0);
      push(32'h5000_0002, 64'h504, 1'b0);
      push(32'h5000_0003, 64'h508, 1'b0);
      push(32'h5000_0004, 64'h50C, 1'b0);
      cycle(1'b1, 32'h5BAD_0005, 64'h510, 1'b1, 1'b1, 1'b1);
      idle(1'b1, 1);
      push(32'h6000_0001, 64'h600, 1'b1);
      idle(1'b1, 2);

      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d unpopped entries expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_queue

`default_nettype wire
